// File: rtl/video_scan_timing.sv
// Raster timing for the Apple-1 40x24 text display.
// Walks the raster at the pixel_clken rate and emits sync, blanking, the
// character column/row and the glyph pixel indices. All outputs are registered
// from next-state values, so they line up with the counter position they describe.
// Optional feature: define CURSOR_BLINK_EN to build the cursor-blink frame
// counter. Without it, blink is tied high and the cursor is steady.
module video_scan_timing #(
  parameter int unsigned H_TOTAL      = 448,
  parameter int unsigned H_ACTIVE     = 280,
  parameter int unsigned H_SYNC_START = 320,
  parameter int unsigned H_SYNC_LEN   = 32,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned V_ACTIVE     = 192,
  parameter int unsigned V_SYNC_START = 224,
  parameter int unsigned V_SYNC_LEN   = 3,
  parameter bit          SYNC_POL     = 1'b0
`ifdef CURSOR_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 16
`endif
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       pixel_clken,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [5:0] char_col,
  output logic [4:0] char_row,
  output logic [2:0] pix_x,
  output logic [2:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       blink
);

  localparam logic [8:0] HLast      = 9'(H_TOTAL - 1);
  localparam logic [8:0] HActive    = 9'(H_ACTIVE);
  localparam logic [8:0] HSyncStart = 9'(H_SYNC_START);
  localparam logic [8:0] HSyncEnd   = 9'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0] VLast      = 9'(V_TOTAL - 1);
  localparam logic [8:0] VActive    = 9'(V_ACTIVE);
  localparam logic [8:0] VSyncStart = 9'(V_SYNC_START);
  localparam logic [8:0] VSyncEnd   = 9'(V_SYNC_START + V_SYNC_LEN);
  localparam logic       SyncOn     = SYNC_POL;
  localparam logic       SyncOff    = ~SYNC_POL;

  // Raster position
  logic [8:0] h_cnt_q, h_cnt_d;
  logic [8:0] v_cnt_q, v_cnt_d;
  logic       h_wrap, v_wrap;

  // Registered outputs and their next-state values
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic [5:0] char_col_q, char_col_d;
  logic [4:0] char_row_q, char_row_d;
  logic [2:0] pix_x_q, pix_x_d;
  logic [2:0] pix_y_q, pix_y_d;
  logic       line_start_q, frame_start_q;
  logic       h_vis, v_vis;

  // Next raster position; v only moves on the horizontal wrap
  always_comb begin
    h_wrap  = (h_cnt_q == HLast);
    v_wrap  = h_wrap && (v_cnt_q == VLast);
    h_cnt_d = h_wrap ? 9'd0 : h_cnt_q + 9'd1;
    if (v_wrap) begin
      v_cnt_d = 9'd0;
    end else if (h_wrap) begin
      v_cnt_d = v_cnt_q + 9'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Output next-state, derived from the next raster position
  always_comb begin
    h_vis = (h_cnt_d < HActive);
    v_vis = (v_cnt_d < VActive);

    // Glyph column is a mod-7 counter carrying into the character column,
    // restarted at the left edge and parked at 0 through horizontal blanking.
    if (!h_vis || (h_cnt_d == 9'd0)) begin
      pix_x_d    = 3'd0;
      char_col_d = 6'd0;
    end else if (pix_x_q == 3'd6) begin
      pix_x_d    = 3'd0;
      char_col_d = char_col_q + 6'd1;
    end else begin
      pix_x_d    = pix_x_q + 3'd1;
      char_col_d = char_col_q;
    end

    // Eight scanlines per glyph row, so the row split is just bit slicing
    pix_y_d    = v_vis ? v_cnt_d[2:0] : 3'd0;
    char_row_d = v_vis ? v_cnt_d[7:3] : 5'd0;

    active_d = h_vis && v_vis;
    hsync_d  = ((h_cnt_d >= HSyncStart) && (h_cnt_d < HSyncEnd)) ? SyncOn : SyncOff;
    vsync_d  = ((v_cnt_d >= VSyncStart) && (v_cnt_d < VSyncEnd)) ? SyncOn : SyncOff;
  end

  // Counter and output registers; everything holds while pixel_clken is low
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      h_cnt_q    <= 9'd0;
      v_cnt_q    <= 9'd0;
      hsync_q    <= SyncOff;
      vsync_q    <= SyncOff;
      active_q   <= 1'b1;
      char_col_q <= 6'd0;
      char_row_q <= 5'd0;
      pix_x_q    <= 3'd0;
      pix_y_q    <= 3'd0;
    end else if (pixel_clken) begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      active_q   <= active_d;
      char_col_q <= char_col_d;
      char_row_q <= char_row_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
    end
  end

  // Wrap pulses last one sys_clock cycle, cleared even when pixel_clken is low
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= pixel_clken && h_wrap;
      frame_start_q <= pixel_clken && v_wrap;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(BLINK_FRAMES - 1);

  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_q, blink_d;

  // Count frame wraps; flip the blink phase on every BLINK_FRAMES-th one
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (pixel_clken && v_wrap) begin
      if (frame_cnt_q == FcLast) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Blink phase register
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign char_col    = char_col_q;
  assign char_row    = char_row_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_scan_timing.sv
// Directed bench for video_scan_timing: a default-sized instance for the line
// timing, hold and mid-line reset, plus a shrunken active-high-sync instance
// that covers whole frames quickly.
module tb_video_scan_timing;

  logic sys_clock = 1'b0;
  logic reset     = 1'b1;
  logic pixel_clken   = 1'b0;
  logic s_pixel_clken = 1'b0;

  logic       hsync, vsync, active, line_start, frame_start, blink;
  logic [5:0] char_col;
  logic [4:0] char_row;
  logic [2:0] pix_x, pix_y;

  logic       s_hsync, s_vsync, s_active, s_line_start, s_frame_start, s_blink;
  logic [5:0] s_char_col;
  logic [4:0] s_char_row;
  logic [2:0] s_pix_x, s_pix_y;

  int checks   = 0;
  int failures = 0;

`ifdef CURSOR_BLINK_EN
  localparam logic BlinkRst = 1'b0;
`else
  localparam logic BlinkRst = 1'b1;
`endif

  video_scan_timing dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .pixel_clken (pixel_clken),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .char_col    (char_col),
    .char_row    (char_row),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .blink       (blink)
  );

  video_scan_timing #(
    .H_TOTAL      (20),
    .H_ACTIVE     (14),
    .H_SYNC_START (16),
    .H_SYNC_LEN   (2),
    .V_TOTAL      (30),
    .V_ACTIVE     (16),
    .V_SYNC_START (20),
    .V_SYNC_LEN   (3),
    .SYNC_POL     (1'b1)
  ) dut_small (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .pixel_clken (s_pixel_clken),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .active      (s_active),
    .char_col    (s_char_col),
    .char_row    (s_char_row),
    .pix_x       (s_pix_x),
    .pix_y       (s_pix_y),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .blink       (s_blink)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n enabled edges on the main instance; returns #1 after the last edge
  task automatic run_main(input int n);
    pixel_clken = 1'b1;
    repeat (n) @(posedge sys_clock);
    #1 pixel_clken = 1'b0;
  endtask

  task automatic run_small(input int n);
    s_pixel_clken = 1'b1;
    repeat (n) @(posedge sys_clock);
    #1 s_pixel_clken = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_active"}, active, 1);
    chk({tag, "_col"}, char_col, 0);
    chk({tag, "_row"}, char_row, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_line_start"}, line_start, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_blink"}, blink, BlinkRst);
  endtask

  initial begin
    int hval, low_cnt, low_first, low_last, ls_cnt, ls_h, fs_cnt, changes;
    int th, tv, mism, s_ls, s_fs, s_vs, s_hs, fs_no_ls;
    logic [22:0] snap, prev;

    // Reset state
    repeat (3) @(posedge sys_clock);
    #1 reset = 1'b0;
    #1;
    chk_reset_vals("rst");
    chk("s_rst_hsync", s_hsync, 0);
    chk("s_rst_vsync", s_vsync, 0);
    chk("s_rst_active", s_active, 1);

    // Column and glyph pixel progression along the first line
    run_main(7);
    chk("h7_col", char_col, 1);
    chk("h7_pix_x", pix_x, 0);
    chk("h7_active", active, 1);
    run_main(272);
    chk("h279_col", char_col, 39);
    chk("h279_pix_x", pix_x, 6);
    chk("h279_active", active, 1);
    run_main(1);
    chk("h280_active", active, 0);
    chk("h280_col", char_col, 0);
    chk("h280_pix_x", pix_x, 0);

    // Walk the rest of the line one enable at a time
    low_cnt = 0; low_first = -1; low_last = -1; ls_cnt = 0; ls_h = -1; fs_cnt = 0;
    for (int k = 1; k <= 168; k++) begin
      run_main(1);
      hval = (280 + k) % 448;
      if (hsync == 1'b0) begin
        low_cnt++;
        if (low_first < 0) low_first = hval;
        low_last = hval;
      end
      if (line_start) begin
        ls_cnt++;
        ls_h = hval;
      end
      if (frame_start) fs_cnt++;
    end
    chk("hsync_low_count", low_cnt, 32);
    chk("hsync_low_first", low_first, 320);
    chk("hsync_low_last", low_last, 351);
    chk("line_start_count", ls_cnt, 1);
    chk("line_start_at_h", ls_h, 0);
    chk("line_frame_start", fs_cnt, 0);
    chk("l1_pix_y", pix_y, 1);
    chk("l1_row", char_row, 0);
    chk("l1_col", char_col, 0);
    chk("l1_active", active, 1);
    @(posedge sys_clock); #1;
    chk("line_start_clear_idle", line_start, 0);
    chk("l1_pix_y_hold", pix_y, 1);

    // Small instance: one full frame against the timing rules
    th = 0; tv = 0; mism = 0; s_ls = 0; s_fs = 0; s_vs = 0; s_hs = 0; fs_no_ls = 0;
    for (int k = 0; k < 600; k++) begin
      run_small(1);
      th = (th == 19) ? 0 : th + 1;
      if (th == 0) tv = (tv == 29) ? 0 : tv + 1;
      if (s_active !== ((th < 14) && (tv < 16))) mism++;
      if (s_char_col !== 6'((th < 14) ? th / 7 : 0)) mism++;
      if (s_pix_x !== 3'((th < 14) ? th % 7 : 0)) mism++;
      if (s_pix_y !== 3'((tv < 16) ? tv % 8 : 0)) mism++;
      if (s_char_row !== 5'((tv < 16) ? tv / 8 : 0)) mism++;
      if (s_hsync !== ((th >= 16) && (th < 18))) mism++;
      if (s_vsync !== ((tv >= 20) && (tv < 23))) mism++;
      if (s_line_start !== (th == 0)) mism++;
      if (s_frame_start !== ((th == 0) && (tv == 0))) mism++;
      if (s_line_start) s_ls++;
      if (s_frame_start) s_fs++;
      if (s_frame_start && !s_line_start) fs_no_ls++;
      if (s_vsync) s_vs++;
      if (s_hsync) s_hs++;
    end
    chk("s_frame_mismatches", mism, 0);
    chk("s_line_start_count", s_ls, 30);
    chk("s_frame_start_count", s_fs, 1);
    chk("s_fs_implies_ls", fs_no_ls, 0);
    chk("s_vsync_enables", s_vs, 60);
    chk("s_hsync_enables", s_hs, 60);
    chk("s_blink_after_1", s_blink, BlinkRst);

`ifdef CURSOR_BLINK_EN
    run_small(14 * 600);
    chk("s_blink_after_15", s_blink, 0);
    run_small(600);
    chk("s_blink_after_16", s_blink, 1);
    run_small(16 * 600);
    chk("s_blink_after_32", s_blink, 0);
`endif

    // Main instance: move to v=50, h=100
    run_main(49 * 448 + 100);
    chk("v50_pix_y", pix_y, 2);
    chk("v50_row", char_row, 6);
    chk("v50_col", char_col, 14);
    chk("v50_pix_x", pix_x, 2);
    chk("v50_active", active, 1);
    chk("v50_hsync", hsync, 1);
    chk("v50_vsync", vsync, 1);

    // Enable held low: nothing may move
    changes = 0;
    prev = {hsync, vsync, active, char_col, char_row, pix_x, pix_y,
            line_start, frame_start, blink};
    repeat (1000) begin
      @(posedge sys_clock); #1;
      snap = {hsync, vsync, active, char_col, char_row, pix_x, pix_y,
              line_start, frame_start, blink};
      if (snap !== prev) changes++;
    end
    chk("hold_changes", changes, 0);

    // Asynchronous reset mid-line
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(posedge sys_clock);
    #1 reset = 1'b0;
    chk_reset_vals("mid_rel");
    run_main(1);
    chk("post_rst_pix_x", pix_x, 1);
    chk("post_rst_col", char_col, 0);
    chk("post_rst_line_start", line_start, 0);
    chk("post_rst_frame_start", frame_start, 0);
    run_main(6);
    chk("post_rst_h7_col", char_col, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
